// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (instruction / data cache) line-fill and writeback
//                arbiter in front of a single downstream memory port. One
//                transaction is in flight at a time. Contention alternates
//                between the ports, and each port has a saturating counter
//                of completed transactions.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    // Instruction cache port (read only)
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    // Data cache port (read and writeback)
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    // Downstream memory
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    // Status
    output logic              busy,
    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_served_d;  // 0: I served last, 1: D served last
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [31:0]         r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_i_cnt;
    logic [CNT_W-1:0]    r_d_cnt;

    logic                w_d_req;
    logic                w_grant_d;
    logic                w_grant_i;

    // Arbitration: D wins if it alone requests, or on contention when I was
    // served last (which is also the reset value, so D wins the first tie).
    assign w_d_req   = d_read | d_write;
    assign w_grant_d = w_d_req & (~i_read | ~r_last_served_d);
    assign w_grant_i = i_read & ~w_grant_d;

    // Main FSM: grant, latch the request, hold the pmem operation until
    // pmem_resp, then return to IDLE and account for the completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_last_served_d <= 1'b0;
            r_pmem_read     <= 1'b0;
            r_pmem_write    <= 1'b0;
            r_addr          <= 32'd0;
            r_wdata         <= '0;
            r_i_cnt         <= '0;
            r_d_cnt         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        // A simultaneous read and write is treated as a write.
                        r_state      <= SERVE_D;
                        r_pmem_read  <= ~d_write;
                        r_pmem_write <= d_write;
                        r_addr       <= d_addr;
                        r_wdata      <= d_wdata;
                    end else if (w_grant_i) begin
                        r_state      <= SERVE_I;
                        r_pmem_read  <= 1'b1;
                        r_pmem_write <= 1'b0;
                        r_addr       <= i_addr;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        r_state         <= IDLE;
                        r_last_served_d <= 1'b0;
                        r_pmem_read     <= 1'b0;
                        r_pmem_write    <= 1'b0;
                        if (r_i_cnt != {CNT_W{1'b1}}) begin
                            r_i_cnt <= r_i_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        r_state         <= IDLE;
                        r_last_served_d <= 1'b1;
                        r_pmem_read     <= 1'b0;
                        r_pmem_write    <= 1'b0;
                        if (r_d_cnt != {CNT_W{1'b1}}) begin
                            r_d_cnt <= r_d_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Downstream side always reflects the latched transaction.
    assign pmem_read     = r_pmem_read;
    assign pmem_write    = r_pmem_write;
    assign pmem_address  = r_addr;
    assign pmem_wdata    = r_wdata;

    // Read data is broadcast; only the served port sees a response pulse.
    // A pmem_resp arriving in IDLE produces no pulse.
    assign i_rdata       = pmem_rdata;
    assign d_rdata       = pmem_rdata;
    assign i_resp        = pmem_resp & (r_state == SERVE_I);
    assign d_resp        = pmem_resp & (r_state == SERVE_D);

    assign busy          = (r_state != IDLE);
    assign i_grant_count = r_i_cnt;
    assign d_grant_count = r_d_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter (CNT_W=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_read;
    logic [31:0]       i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [31:0]       d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              busy;
    logic [CNT_W-1:0]  i_grant_count;
    logic [CNT_W-1:0]  d_grant_count;

    int checks = 0;
    int errors = 0;

    logic [LINE_W-1:0] pat_a5;
    logic [LINE_W-1:0] pat_rd;

    mem_arbiter #(.LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy),
        .i_grant_count(i_grant_count),
        .d_grant_count(d_grant_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each step ends at the falling edge: inputs change and outputs are sampled there.
    task automatic step();
        @(negedge clk);
    endtask

    // One complete data-read transaction with an idle cycle afterwards.
    task automatic d_txn();
        d_read = 1'b1;
        step();                 // granted, SERVE_D
        pmem_resp = 1'b1;
        step();                 // back in IDLE
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        step();
    endtask

    initial begin
        pat_a5     = {32{8'hA5}};
        pat_rd     = {8{32'hDEAD_BEEF}};
        reset      = 1'b1;
        i_read     = 1'b0;
        i_addr     = 32'd0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = 32'd0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        step();
        step();

        // ---------------- reset state
        chk("rst_busy",   busy,          0);
        chk("rst_pread",  pmem_read,     0);
        chk("rst_pwrite", pmem_write,    0);
        chk("rst_paddr",  pmem_address,  0);
        chk("rst_icnt",   i_grant_count, 0);
        chk("rst_dcnt",   d_grant_count, 0);
        reset = 1'b0;
        step();

        // ---------------- I read, address held while in service
        i_read = 1'b1;
        i_addr = 32'h0000_1000;
        step();                                  // N+1
        chk("i_pread",  pmem_read,    1);
        chk("i_pwrite", pmem_write,   0);
        chk("i_paddr",  pmem_address, 32'h1000);
        chk("i_busy",   busy,         1);
        chk("i_noresp", i_resp,       0);
        i_addr = 32'h0000_3000;
        step();
        chk("i_addr_hold", pmem_address, 32'h1000);
        step();
        chk("i_pread_hold", pmem_read, 1);
        pmem_rdata = pat_rd;
        pmem_resp  = 1'b1;
        #1;
        chk("i_resp",     i_resp,  1);
        chk("i_d_noresp", d_resp,  0);
        chk("i_rdata",    i_rdata, pat_rd);
        chk("d_rdata",    d_rdata, pat_rd);
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        #1;
        chk("i_resp_end", i_resp,        0);
        chk("i_idle",     busy,          0);
        chk("i_cnt1",     i_grant_count, 1);
        chk("i_pread0",   pmem_read,     0);
        step();

        // ---------------- D writeback
        d_write = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = pat_a5;
        step();
        chk("dw_pwrite", pmem_write,   1);
        chk("dw_pread",  pmem_read,    0);
        chk("dw_paddr",  pmem_address, 32'h2000);
        chk("dw_wdata",  pmem_wdata,   pat_a5);
        d_wdata = '0;
        pmem_resp = 1'b1;
        #1;
        chk("dw_resp",    d_resp,     1);
        chk("dw_i_noresp", i_resp,    0);
        chk("dw_wdata_hold", pmem_wdata, pat_a5);
        step();
        pmem_resp = 1'b0;
        d_write   = 1'b0;
        #1;
        chk("dw_cnt1", d_grant_count, 1);
        chk("dw_idle", busy,          0);
        chk("dw_icnt", i_grant_count, 1);
        step();

        // ---------------- pmem_resp in IDLE is ignored
        pmem_resp = 1'b1;
        #1;
        chk("idle_iresp", i_resp, 0);
        chk("idle_dresp", d_resp, 0);
        step();
        pmem_resp = 1'b0;
        chk("idle_icnt", i_grant_count, 1);
        chk("idle_dcnt", d_grant_count, 1);
        chk("idle_busy", busy,          0);

        // ---------------- read+write together latches a write
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_6000;
        step();
        chk("rw_pwrite", pmem_write, 1);
        chk("rw_pread",  pmem_read,  0);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        step();

        // ---------------- contention from reset: D, I, D
        reset  = 1'b1;
        i_read = 1'b1;
        d_read = 1'b1;
        i_addr = 32'h0000_5000;
        d_addr = 32'h0000_4000;
        step();
        reset = 1'b0;
        chk("ct_rst_busy", busy, 0);
        step();
        chk("ct1_paddr", pmem_address, 32'h4000);
        chk("ct1_pread", pmem_read,    1);
        pmem_resp = 1'b1;
        #1;
        chk("ct1_dresp", d_resp, 1);
        chk("ct1_iresp", i_resp, 0);
        step();                                  // M+1: IDLE
        pmem_resp = 1'b0;
        chk("ct_gap_busy", busy, 0);
        step();                                  // M+2: SERVE_I
        chk("ct2_paddr", pmem_address, 32'h5000);
        chk("ct2_busy",  busy,         1);
        pmem_resp = 1'b1;
        #1;
        chk("ct2_iresp", i_resp, 1);
        chk("ct2_dresp", d_resp, 0);
        step();
        pmem_resp = 1'b0;
        step();
        chk("ct3_paddr", pmem_address, 32'h4000);
        pmem_resp = 1'b1;
        #1;
        chk("ct3_dresp", d_resp, 1);
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        d_read    = 1'b0;
        chk("ct_dcnt", d_grant_count, 2);
        chk("ct_icnt", i_grant_count, 1);
        step();

        // ---------------- reset abandons SERVE_I
        reset = 1'b1;
        step();
        reset  = 1'b0;
        i_read = 1'b1;
        i_addr = 32'h0000_7000;
        step();
        chk("ab_busy_serve", busy, 1);
        reset  = 1'b1;
        i_read = 1'b0;
        step();
        reset = 1'b0;
        chk("ab_busy",  busy,         0);
        chk("ab_pread", pmem_read,    0);
        chk("ab_paddr", pmem_address, 0);
        pmem_resp = 1'b1;
        #1;
        chk("ab_iresp", i_resp, 0);
        step();
        pmem_resp = 1'b0;
        chk("ab_icnt", i_grant_count, 0);
        chk("ab_dcnt", d_grant_count, 0);
        chk("ab_busy2", busy,         0);

        // ---------------- counter saturation: 18 D transactions
        d_addr = 32'h0000_8000;
        for (int k = 0; k < 14; k++) d_txn();
        chk("sat_14", d_grant_count, 4'hE);
        d_txn();
        chk("sat_15", d_grant_count, 4'hF);
        for (int k = 0; k < 3; k++) d_txn();
        chk("sat_18", d_grant_count, 4'hF);
        chk("sat_icnt", i_grant_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, width in bits of one cache line on every data bus.
REQ-002 SHALL have parameter CNT_W, default 16, width of each grant counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_read  in  1  instruction-cache line fill request.
REQ-006 i_addr  in  32  instruction line address.
REQ-007 i_rdata  out  LINE_W  fill data to the instruction cache.
REQ-008 i_resp  out  1  one-cycle completion pulse to the instruction cache.
REQ-009 d_read  in  1  data-cache line fill request.
REQ-010 d_write  in  1  data-cache line writeback request.
REQ-011 d_addr  in  32  data line address.
REQ-012 d_wdata  in  LINE_W  writeback line.
REQ-013 d_rdata  out  LINE_W  fill data to the data cache.
REQ-014 d_resp  out  1  one-cycle completion pulse to the data cache.
REQ-015 pmem_read, pmem_write  out  1 each  downstream memory operation.
REQ-016 pmem_address  out  32  downstream address.
REQ-017 pmem_wdata  out  LINE_W  downstream write line.
REQ-018 pmem_rdata  in  LINE_W  downstream read line.
REQ-019 pmem_resp  in  1  downstream completion pulse.
REQ-020 busy  out  1  high whenever a transaction is in flight.
REQ-021 i_grant_count, d_grant_count  out  CNT_W each  completed transactions per port.

Function
REQ-022 SHALL implement the states IDLE, SERVE_I and SERVE_D.
REQ-023 IDLE, only i_read high -> SERVE_I; only d_read or d_write high -> SERVE_D; none -> stay in IDLE.
REQ-024 IDLE, both ports requesting -> grant the port not served last; the last_served flag resets to I, so the first contention goes to D.
REQ-025 On the IDLE->SERVE_x edge, SHALL latch the operation, address and (for D) wdata; later requester input changes SHALL NOT affect the transaction in flight.
REQ-026 d_read and d_write both high at grant -> SHALL latch a write.
REQ-027 In SERVE_x, pmem_read/pmem_write SHALL equal the latched operation and stay asserted until pmem_resp.
REQ-028 pmem_address and pmem_wdata SHALL come from the latched registers in every state.
REQ-029 i_rdata and d_rdata SHALL equal pmem_rdata combinationally.
REQ-030 x_resp SHALL equal pmem_resp AND state==SERVE_x; the other port's resp SHALL stay 0.
REQ-031 pmem_resp in SERVE_x -> IDLE next cycle, last_served<=x, x_grant_count+1.
REQ-032 Counters SHALL saturate at all-ones, with no wrap.
REQ-033 pmem_resp while in IDLE SHALL be ignored: no resp, no count change.
REQ-034 Latency: request first high in cycle N -> pmem op asserted in N+1; pmem_resp in cycle M -> x_resp in M, IDLE in M+1, earliest next grant M+2.
REQ-035 Requesters SHALL hold a request until their resp and deassert it in the cycle after; a request dropped mid-service SHALL still complete and pulse resp.
REQ-036 busy SHALL equal (state != IDLE).

Reset
REQ-037 reset high at an edge SHALL drive state to IDLE, last_served to I, counters to 0 and the latched address/wdata/op to 0, regardless of state.
REQ-038 After reset, pmem_read=pmem_write=0, i_resp=d_resp=0, busy=0, pmem_address=0 from the next cycle on.
REQ-039 Reset during SERVE_x SHALL abandon the transaction with no resp; a later pmem_resp SHALL be ignored per REQ-033.

Verification
REQ-040 i_read, i_addr=0x0000_1000; pmem_resp 3 cycles later -> pmem_read at N+1, pmem_address=0x1000, i_resp one cycle, i_grant_count=1.
REQ-041 d_write, d_addr=0x2000, d_wdata=all-0xA5 -> pmem_write=1, pmem_wdata=all-0xA5, d_resp on pmem_resp, d_grant_count=1.
REQ-042 i_read and d_read both held from reset -> SERVE_D first, then SERVE_I at M+2, then D: strict alternation.
REQ-043 reset pulsed during SERVE_I, then pmem_resp -> no i_resp, counts stay 0, busy=0.
REQ-044 d_grant_count preloaded near max via 2^CNT_W+2 transactions (CNT_W=4 build) -> holds 0xF.
REQ-045 i_addr changed mid-service from 0x1000 to 0x3000 -> pmem_address stays 0x1000 until resp.
